dw02_mult_2_stage_rtl: RTL and testbench
========================================

DW02_MULT_2_STAGE_RTL -- requirements
Module: dw02_mult_2_stage

Interface
REQ-001 SHALL provide parameter A_width, default 8, meaning bit width of operand A (legal range >= 1).
REQ-002 SHALL provide parameter B_width, default 8, meaning bit width of operand B (legal range >= 1).
REQ-003 SHALL provide port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL provide port A  input  A_width  multiplicand.
REQ-006 SHALL provide port B  input  B_width  multiplier.
REQ-007 SHALL provide port TC  input  1  operand format: 1 = two's complement, 0 = unsigned.
REQ-008 SHALL provide port PRODUCT  output  A_width+B_width  registered product.
REQ-009 SHALL use one clock domain with a synchronous, active-low reset; the polarity and synchronicity are fixed.

Function
REQ-010 SHALL compute the full-precision product A*B with no truncation, rounding or saturation.
REQ-011 SHALL, when TC=1, treat A and B as signed and sign-extend the product to A_width+B_width bits.
REQ-012 SHALL, when TC=0, treat A and B as unsigned and zero-extend the product.
REQ-013 SHALL sample A, B and TC together on rising edge N and present their product on PRODUCT after edge N, stable until edge N+1.
REQ-014 SHALL have a latency of exactly 1 clock.
REQ-015 SHALL accept new operands every cycle (throughput 1), with no enable, stall or handshake.
REQ-016 SHALL apply a TC change only to the operands sampled on the same edge; earlier products are unaffected.
REQ-017 SHALL split the datapath into two stages:
  - stage 1: partial-product generation plus carry-save reduction to a sum/carry vector pair, registered at the clock edge;
  - stage 2: final carry-propagate addition, driven combinationally onto PRODUCT.
REQ-018 SHALL keep PRODUCT free of combinational paths from A, B or TC.
REQ-019 SHALL be bit-exact to a behavioural A*B for all operand values, including the most negative values, zero and all-ones.

Reset
REQ-020 SHALL clear all pipeline registers at any rising CLK edge where reset_n=0, making PRODUCT = 0.
REQ-021 SHALL hold PRODUCT = 0 from the first reset edge through the first edge with reset_n=1. At that edge, PRODUCT SHALL become the product of the operands sampled there.
REQ-022 SHALL discard any operand pair in flight when reset asserts mid-stream; it never appears on PRODUCT.
REQ-023 SHALL NOT respond asynchronously to reset_n.

Configuration
REQ-024 SHALL support the macro DW02_MULT_2_STAGE_CHECK_EN.
REQ-025 SHALL, when DW02_MULT_2_STAGE_CHECK_EN is defined:
  - include simulation-only checks that flag an error at elaboration if A_width<1 or B_width<1;
  - flag an error at any rising CLK edge with reset_n=1 where TC, A or B contains X/Z.
REQ-026 SHALL, when DW02_MULT_2_STAGE_CHECK_EN is undefined, contain no such checks; synthesizable behaviour SHALL be identical in both cases.

Verification (A_width=B_width=32)
REQ-027 SHALL verify signed corner products (TC=1):
  - A=0x7FFFFFFF, B=0x7FFFFFFF -> PRODUCT=0x3FFFFFFF00000001 one edge later;
  - A=0x80000000, B=0x80000000 -> PRODUCT=0x4000000000000000.
REQ-028 SHALL verify TC interpretation with A=0xFFFFFFFF, B=0x00000002:
  - TC=1 -> PRODUCT=0xFFFFFFFFFFFFFFFE;
  - TC=0 -> PRODUCT=0x00000001FFFFFFFE.
REQ-029 SHALL verify unsigned all-ones (TC=0): A=B=0xFFFFFFFF -> PRODUCT=0xFFFFFFFE00000001.
REQ-030 SHALL verify streaming: 1000 random back-to-back pairs with random TC -> each PRODUCT matches the reference model exactly 1 cycle later, with no bubbles.
REQ-031 SHALL verify reset behaviour:
  - reset_n=0 for one edge mid-stream -> PRODUCT=0 after that edge, in-flight pair discarded;
  - next edge with reset_n=1 and A=3, B=-5, TC=1 -> PRODUCT=0xFFFFFFFFFFFFFFF1.
REQ-032 SHALL verify the check macro: with DW02_MULT_2_STAGE_CHECK_EN defined, driving TC=X while reset_n=1 -> error reported; without the macro -> no report.

Source files
------------

// File: rtl/dw02_mult_2_stage_rtl.sv
// rtl/dw02_mult_2_stage_rtl.sv - two-stage signed/unsigned multiplier (optional checks: DW02_MULT_2_STAGE_CHECK_EN)
module dw02_mult_2_stage_rtl #(
   parameter int A_width = 8,
   parameter int B_width = 8
) (
   input  logic                       CLK,
   input  logic                       reset_n,
   input  logic [A_width-1:0]         A,
   input  logic [B_width-1:0]         B,
   input  logic                       TC,
   output logic [A_width+B_width-1:0] PRODUCT
);

   localparam int W = A_width + B_width;

   // Both operands are widened to the full product width. With TC=1 they are
   // sign-extended, so the modulo-2^W product of the widened values is the
   // exact two's complement product; with TC=0 they are zero-extended.
   logic [W-1:0] a_ext;
   logic [W-1:0] b_ext;

   // Carry-save accumulator pair, combinational (stage 1) and registered.
   logic [W-1:0] sum_d;
   logic [W-1:0] carry_d;
   logic [W-1:0] sum_q;
   logic [W-1:0] carry_q;

   // operand widening according to TC
   always_comb begin
      a_ext = {{B_width{TC & A[A_width-1]}}, A};
      b_ext = {{A_width{TC & B[B_width-1]}}, B};
   end

   // stage 1: partial products folded into a sum/carry pair by a chain of 3:2 compressors
   always_comb begin
      logic [W-1:0] row;
      logic [W-1:0] s;
      logic [W-1:0] c;
      s = '0;
      c = '0;
      row = '0;
      for (int i = 0; i < W; i++) begin
         row = b_ext[i] ? (a_ext << i) : '0;
         {s, c} = {s ^ c ^ row, ((s & c) | (s & row) | (c & row)) << 1};
      end
      sum_d   = s;
      carry_d = c;
   end

   // pipeline register between reduction and final addition, cleared by reset
   always_ff @(posedge CLK) begin
      if (!reset_n) begin
         sum_q   <= '0;
         carry_q <= '0;
      end else begin
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   // stage 2: carry-propagate add from registered state only
   always_comb begin
      PRODUCT = sum_q + carry_q;
   end

`ifdef DW02_MULT_2_STAGE_CHECK_EN
   if (A_width < 1) begin : g_bad_a_width
      $error("dw02_mult_2_stage_rtl: A_width must be >= 1");
   end
   if (B_width < 1) begin : g_bad_b_width
      $error("dw02_mult_2_stage_rtl: B_width must be >= 1");
   end

   // flag unknown operands whenever they are actually captured
   always @(posedge CLK) begin
      if (reset_n === 1'b1 && $isunknown({TC, A, B})) begin
         $error("dw02_mult_2_stage_rtl: X/Z on TC, A or B at active clock edge");
      end
   end
`endif

endmodule

// File: tb/tb_dw02_mult_2_stage_rtl.sv
// tb/tb_dw02_mult_2_stage_rtl.sv - directed and streaming bench for dw02_mult_2_stage_rtl
module tb_dw02_mult_2_stage_rtl;

   logic        CLK;
   logic        reset_n;
   logic [31:0] A;
   logic [31:0] B;
   logic        TC;
   logic [63:0] PRODUCT;

   int n_cmp;
   int n_fail;

   dw02_mult_2_stage_rtl #(.A_width(32), .B_width(32)) dut (
      .CLK     (CLK),
      .reset_n (reset_n),
      .A       (A),
      .B       (B),
      .TC      (TC),
      .PRODUCT (PRODUCT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic tc);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      if (tc) begin
         sa = $signed({{32{a[31]}}, a});
         sb = $signed({{32{b[31]}}, b});
         return 64'(sa * sb);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   // drive operands on the falling edge, then wait just past the capturing edge
   task automatic drive_and_capture(input logic [31:0] a, input logic [31:0] b, input logic tc, input logic rn);
      @(negedge CLK);
      A = a;
      B = b;
      TC = tc;
      reset_n = rn;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive_and_capture(32'h1234_5678 + 32'(i), 32'h9ABC_DEF0, 1'b1, 1'b0);
         n_cmp++;
         if (PRODUCT !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_hold[%0d]: got %h expected %h", i, PRODUCT, 64'h0);
         end
      end
      drive_and_capture(32'd5, 32'd6, 1'b0, 1'b1);
      n_cmp++;
      if (PRODUCT !== 64'd30) begin
         n_fail++;
         $display("FAIL reset_release: got %h expected %h", PRODUCT, 64'd30);
      end
   endtask

   task automatic test_signed_corners();
      drive_and_capture(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1);
      n_cmp++;
      if (PRODUCT !== 64'h3FFF_FFFF_0000_0001) begin
         n_fail++;
         $display("FAIL signed_maxpos: got %h expected %h", PRODUCT, 64'h3FFF_FFFF_0000_0001);
      end
      drive_and_capture(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
      n_cmp++;
      if (PRODUCT !== 64'h4000_0000_0000_0000) begin
         n_fail++;
         $display("FAIL signed_maxneg: got %h expected %h", PRODUCT, 64'h4000_0000_0000_0000);
      end
      drive_and_capture(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1);
      n_cmp++;
      if (PRODUCT !== 64'hC000_0000_8000_0000) begin
         n_fail++;
         $display("FAIL signed_neg_pos: got %h expected %h", PRODUCT, 64'hC000_0000_8000_0000);
      end
      drive_and_capture(32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);
      n_cmp++;
      if (PRODUCT !== 64'h0) begin
         n_fail++;
         $display("FAIL signed_zero: got %h expected %h", PRODUCT, 64'h0);
      end
      // product must stay put until the next capturing edge
      @(negedge CLK);
      n_cmp++;
      if (PRODUCT !== 64'h0) begin
         n_fail++;
         $display("FAIL signed_zero_stable: got %h expected %h", PRODUCT, 64'h0);
      end
   endtask

   task automatic test_tc_interp();
      drive_and_capture(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b1);
      n_cmp++;
      if (PRODUCT !== 64'hFFFF_FFFF_FFFF_FFFE) begin
         n_fail++;
         $display("FAIL tc1_neg1x2: got %h expected %h", PRODUCT, 64'hFFFF_FFFF_FFFF_FFFE);
      end
      drive_and_capture(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b1);
      n_cmp++;
      if (PRODUCT !== 64'h0000_0001_FFFF_FFFE) begin
         n_fail++;
         $display("FAIL tc0_neg1x2: got %h expected %h", PRODUCT, 64'h0000_0001_FFFF_FFFE);
      end
   endtask

   task automatic test_unsigned_all_ones();
      drive_and_capture(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
      n_cmp++;
      if (PRODUCT !== 64'hFFFF_FFFE_0000_0001) begin
         n_fail++;
         $display("FAIL unsigned_all_ones: got %h expected %h", PRODUCT, 64'hFFFF_FFFE_0000_0001);
      end
      drive_and_capture(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
      n_cmp++;
      if (PRODUCT !== 64'h0000_0000_0000_0001) begin
         n_fail++;
         $display("FAIL signed_all_ones: got %h expected %h", PRODUCT, 64'h1);
      end
   endtask

   // new pair every cycle; each result checked on the following falling edge
   task automatic test_back_to_back();
      logic [63:0] exp_prev;
      logic [31:0] a;
      logic [31:0] b;
      logic        tc;
      int          errs;
      errs = 0;
      exp_prev = '0;
      for (int i = 0; i <= 1000; i++) begin
         @(negedge CLK);
         if (i > 0) begin
            n_cmp++;
            if (PRODUCT !== exp_prev) begin
               n_fail++;
               errs++;
               if (errs <= 10)
                  $display("FAIL stream[%0d]: got %h expected %h", i - 1, PRODUCT, exp_prev);
            end
         end
         if (i < 1000) begin
            a = $urandom;
            b = $urandom;
            tc = 1'($urandom_range(0, 1));
            if (i % 97 == 0) a = 32'h8000_0000;
            if (i % 89 == 0) b = 32'hFFFF_FFFF;
            A = a;
            B = b;
            TC = tc;
            reset_n = 1'b1;
            exp_prev = ref_mul(a, b, tc);
         end
      end
   endtask

   task automatic test_mid_reset();
      drive_and_capture(32'd7, 32'd9, 1'b0, 1'b1);
      n_cmp++;
      if (PRODUCT !== 64'd63) begin
         n_fail++;
         $display("FAIL midrst_pre: got %h expected %h", PRODUCT, 64'd63);
      end
      drive_and_capture(32'd100, 32'd100, 1'b0, 1'b0);
      n_cmp++;
      if (PRODUCT !== 64'h0) begin
         n_fail++;
         $display("FAIL midrst_flush: got %h expected %h", PRODUCT, 64'h0);
      end
      drive_and_capture(32'd3, 32'hFFFF_FFFB, 1'b1, 1'b1);
      n_cmp++;
      if (PRODUCT !== 64'hFFFF_FFFF_FFFF_FFF1) begin
         n_fail++;
         $display("FAIL midrst_after: got %h expected %h", PRODUCT, 64'hFFFF_FFFF_FFFF_FFF1);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      reset_n = 1'b0;
      A = '0;
      B = '0;
      TC = 1'b0;
      test_reset();
      test_signed_corners();
      test_tc_interp();
      test_unsigned_all_ones();
      test_back_to_back();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
